// File: rtl/mcp23s17_master_pkg.sv
// rtl/mcp23s17_master_pkg.sv - shared state codes, opcode and register constants for the MCP23S17 SPI master
package mcp23s17_master_pkg;

    typedef logic [2:0] master_state_t;

    localparam master_state_t MS_IDLE  = 3'd0;
    localparam master_state_t MS_SETUP = 3'd1;
    localparam master_state_t MS_LOW   = 3'd2;
    localparam master_state_t MS_HIGH  = 3'd3;
    localparam master_state_t MS_GAP   = 3'd4;
    localparam master_state_t MS_HOLD  = 3'd5;
    localparam master_state_t MS_DONE  = 3'd6;

    localparam logic [3:0] MCP_OPCODE_HI = 4'b0100;

    localparam logic [7:0] IOCON = 8'h0A;
    localparam logic [7:0] IODIR = 8'h00;
    localparam logic [7:0] GPIO  = 8'h12;

    function automatic logic [7:0] mcp_opcode(input logic [2:0] hw_addr, input logic rw);
        return {MCP_OPCODE_HI, hw_addr, rw};
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/mcp23s17_master_phase_timer.sv
// rtl/mcp23s17_master_phase_timer.sv - loadable down-counter with terminal count, shared by all timed states
module mcp23s17_master_phase_timer #(
    parameter int W = 4
) (
    input  logic         sysClk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    // Loading N-1 makes a state last exactly N cycles; tc marks its last cycle.
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mcp23s17_master.sv
// rtl/mcp23s17_master.sv - SPI master running 3-byte MCP23S17 register read/write frames
module mcp23s17_master
    import mcp23s17_master_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter int         CS_SETUP = 4,
    parameter int         CS_HOLD  = 4,
    parameter int         BYTE_GAP = 8,
    parameter logic [2:0] HW_ADDR  = 3'b000
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       rw_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       spiClk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int PHASE_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, BYTE_GAP);
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] DIV_LD   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HOLD_LD  = PW'(CS_HOLD - 1);
    localparam logic [PW-1:0] GAP_LD   = PW'(BYTE_GAP - 1);

    master_state_t state, state_next;
    logic [23:0]   tx;
    logic [7:0]    rx;
    logic [4:0]    bit_cnt;
    logic          rw_q;
    logic          mosi_q;
    logic [7:0]    rd_q;
    logic          miso_meta, miso_sync;

    logic          load;
    logic [PW-1:0] load_value;
    logic          tc;

    mcp23s17_master_phase_timer #(.W(PW)) u_timer (
        .sysClk     (sysClk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .tc         (tc)
    );

    // Every state change reloads the timer with the duration of the state being entered.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = '0;
        case (state)
            MS_IDLE: if (req_i) begin
                state_next = MS_SETUP; load = 1'b1; load_value = SETUP_LD;
            end
            MS_SETUP: if (tc) begin
                state_next = MS_LOW; load = 1'b1; load_value = DIV_LD;
            end
            MS_LOW: if (tc) begin
                state_next = MS_HIGH; load = 1'b1; load_value = DIV_LD;
            end
            MS_HIGH: if (tc) begin
                load = 1'b1;
                if (bit_cnt == 5'd0) begin
                    state_next = MS_HOLD; load_value = HOLD_LD;
                end else if (bit_cnt == 5'd16 || bit_cnt == 5'd8) begin
                    state_next = MS_GAP; load_value = GAP_LD;
                end else begin
                    state_next = MS_LOW; load_value = DIV_LD;
                end
            end
            MS_GAP: if (tc) begin
                state_next = MS_LOW; load = 1'b1; load_value = DIV_LD;
            end
            MS_HOLD: if (tc) begin
                state_next = MS_DONE;
            end
            MS_DONE: state_next = MS_IDLE;
            default: state_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            state     <= MS_IDLE;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            rw_q      <= 1'b0;
            mosi_q    <= 1'b0;
            rd_q      <= '0;
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            state     <= state_next;
            miso_meta <= miso_i;
            miso_sync <= miso_meta;

            if (state == MS_IDLE && req_i) begin
                tx      <= {mcp_opcode(HW_ADDR, rw_i), reg_addr_i, wr_data_i};
                rw_q    <= rw_i;
                bit_cnt <= 5'd23;
            end

            if (state == MS_HIGH && tc) begin
                tx      <= {tx[22:0], 1'b0};
                rx      <= {rx[6:0], miso_sync};
                bit_cnt <= bit_cnt - 5'd1;
            end

            // Coming straight from MS_HIGH the shift has not landed yet, so look one bit ahead.
            if (state_next == MS_LOW && state != MS_LOW) begin
                mosi_q <= (state == MS_HIGH) ? tx[22] : tx[23];
            end

            if (state == MS_HOLD && tc && rw_q) begin
                rd_q <= rx;
            end
        end
    end

    assign ready_o   = (state == MS_IDLE);
    assign busy_o    = !ready_o;
    assign done_o    = (state == MS_DONE);
    assign cs_o      = (state == MS_IDLE) || (state == MS_DONE);
    assign spiClk_o  = (state == MS_HIGH);
    assign mosi_o    = mosi_q;
    assign rd_data_o = rd_q;

endmodule

// File: tb/tb_mcp23s17_master.sv
// tb/tb_mcp23s17_master.sv - scoreboard bench for mcp23s17_master against a behavioural SPI slave
module tb_mcp23s17_master;
    import mcp23s17_master_pkg::*;

    localparam int FRAME_LEN  = 1 + 4 + 24 * 2 * 4 + 2 * 8 + 4;
    localparam int FIRST_RISE = 1 + 4 + 4;

    logic       sysClk = 1'b0;
    logic       reset = 1'b0;
    logic       req_i = 1'b0;
    logic       rw_i = 1'b0;
    logic [7:0] reg_addr_i = 8'h00;
    logic [7:0] wr_data_i = 8'h00;
    logic       ready_o, busy_o, done_o, spiClk_o, cs_o, mosi_o, miso_i;
    logic [7:0] rd_data_o;

    always #5 sysClk = ~sysClk;

    int cyc = 0;
    always @(posedge sysClk) cyc <= cyc + 1;

    mcp23s17_master dut (
        .sysClk     (sysClk),
        .reset      (reset),
        .req_i      (req_i),
        .rw_i       (rw_i),
        .reg_addr_i (reg_addr_i),
        .wr_data_i  (wr_data_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_data_o  (rd_data_o),
        .spiClk_o   (spiClk_o),
        .cs_o       (cs_o),
        .mosi_o     (mosi_o),
        .miso_i     (miso_i)
    );

    typedef struct {
        logic [23:0] bits;
        logic [7:0]  rd;
        int          t_acc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem[256];
    logic [7:0] rd_exp = 8'h00;
    logic [7:0] slv_mem[256];
    bit         tie1 = 1'b0;
    bit         gap_check = 1'b0;
    logic       slv_miso = 1'b0;

    assign miso_i = tie1 ? 1'b1 : slv_miso;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // SPI slave: mode 0, response byte for the third byte chosen once opcode and address are in.
    int          srise = 0;
    logic [23:0] ssh = '0;
    logic [7:0]  sresp = '0;
    logic        sprev = 1'b0;
    always @(negedge sysClk) begin
        if (cs_o) begin
            srise = 0; slv_miso = 1'b0; sprev = 1'b0;
        end else begin
            if (spiClk_o && !sprev) begin
                ssh = {ssh[22:0], mosi_o};
                srise++;
                if (srise == 16) sresp = slv_mem[ssh[7:0]];
                if (srise == 24 && ssh[16] == 1'b0) slv_mem[ssh[15:8]] = ssh[7:0];
            end
            if (!spiClk_o && sprev && srise >= 16 && srise < 24) slv_miso = sresp[23 - srise];
            sprev = spiClk_o;
        end
    end

    // Monitor: captures mosi on spiClk rising edges and scores each frame at done_o.
    logic        spi_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic [23:0] cap = '0;
    int          mon_rises = 0;
    int          first_rise = 0;
    int          cs_high = 0;
    exp_t        em;
    always @(negedge sysClk) begin
        if (!reset) begin
            spi_prev = 1'b0; cap = '0; mon_rises = 0; cs_high = 0; cs_prev = 1'b1;
        end else begin
            if (spiClk_o && !spi_prev) begin
                cap = {cap[22:0], mosi_o};
                if (mon_rises == 0) first_rise = cyc;
                mon_rises++;
            end
            spi_prev = spiClk_o;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'(0));
                end else begin
                    em = sb.pop_front();
                    check("mosi_frame", 32'(cap), 32'(em.bits));
                    check("spiclk_rises", 32'(mon_rises), 32'(24));
                    check("rd_data", 32'(rd_data_o), 32'(em.rd));
                    check("frame_len", 32'(cyc - em.t_acc), 32'(FRAME_LEN));
                    check("first_rise", 32'(first_rise - em.t_acc), 32'(FIRST_RISE));
                    check("busy_not_ready", 32'(busy_o), 32'(!ready_o));
                end
                mon_rises = 0;
                cs_high = 0;
            end else if (cs_o) begin
                cs_high++;
            end else if (cs_prev && gap_check) begin
                check("cs_gap_min1", 32'(cs_high >= 1), 32'(1));
            end
            cs_prev = cs_o;
        end
    end

    task automatic send(input logic rw, input logic [7:0] addr, input logic [7:0] data, input bit hold);
        exp_t e;
        int   n = 0;
        while (!ready_o && n < 3000) begin @(negedge sysClk); n++; end
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL ready_timeout actual=busy required=ready");
            return;
        end
        rw_i = rw; reg_addr_i = addr; wr_data_i = data; req_i = 1'b1;
        e.bits = {4'b0100, 3'b000, rw, addr, data};
        if (rw) rd_exp = tie1 ? 8'hFF : ref_mem[addr];
        else ref_mem[addr] = data;
        e.rd = rd_exp;
        e.t_acc = cyc;
        sb.push_back(e);
        @(negedge sysClk);
        if (!hold) req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !ready_o) && n < 3000) begin @(negedge sysClk); n++; end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=pending%0d required=pending0", sb.size());
        end
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (!(mon_rises == target && spiClk_o) && n < 3000) begin @(negedge sysClk); n++; end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL rise_timeout actual=%0d required=%0d", mon_rises, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[8'h0F] = 8'hF9;
        slv_mem[8'h0F] = 8'hF9;

        repeat (3) @(negedge sysClk);
        check("rst_cs", 32'(cs_o), 32'(1));
        check("rst_spiclk", 32'(spiClk_o), 32'(0));
        check("rst_mosi", 32'(mosi_o), 32'(0));
        check("rst_ready", 32'(ready_o), 32'(1));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_rd_data", 32'(rd_data_o), 32'(0));
        reset = 1'b1;
        @(negedge sysClk);

        send(1'b0, IOCON, 8'h28, 1'b0); wait_idle();
        send(1'b1, IOCON, 8'h00, 1'b0); wait_idle();
        send(1'b1, 8'h0F, 8'h00, 1'b0); wait_idle();
        tie1 = 1'b1;
        send(1'b1, 8'h0F, 8'h00, 1'b0); wait_idle();
        tie1 = 1'b0;

        send(1'b0, 8'h05, 8'($urandom), 1'b0);
        wait_rises(6);
        rw_i = 1'b1; reg_addr_i = 8'($urandom); wr_data_i = 8'($urandom); req_i = 1'b1;
        @(negedge sysClk);
        req_i = 1'b0;
        wait_idle();

        send(1'b1, 8'h0F, 8'h00, 1'b0);
        wait_rises(12);
        #1 reset = 1'b0;
        #1;
        check("midrst_cs", 32'(cs_o), 32'(1));
        check("midrst_spiclk", 32'(spiClk_o), 32'(0));
        check("midrst_done", 32'(done_o), 32'(0));
        check("midrst_ready", 32'(ready_o), 32'(1));
        sb.delete();
        rd_exp = 8'h00;
        repeat (3) @(negedge sysClk);
        reset = 1'b1;
        @(negedge sysClk);
        send(1'b0, IODIR, 8'hA5, 1'b0); wait_idle();
        send(1'b1, IODIR, 8'h00, 1'b0); wait_idle();

        gap_check = 1'b1;
        send(1'b0, GPIO, 8'h3C, 1'b1);
        send(1'b1, GPIO, 8'h00, 1'b0);
        wait_idle();
        gap_check = 1'b0;

        for (int k = 0; k < 12; k++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom), 1'b0);
            wait_idle();
        end

        repeat (20) @(negedge sysClk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp23s17_master.md
# mcp23s17_master

SPI master sequencer for an MCP23S17-style register interface. It accepts one register read or write request from the system side and runs the full 3-byte SPI transaction on spiClk/cs/mosi/miso: opcode, register address, then data. It drives the SPISlave emulator in simulation and the real expander on hardware. It also owns CS framing, bit timing, inter-byte gaps and read-data capture.

## Interface
Parameters:
- CLK_DIV, 4: sysClk cycles per spiClk half-period; minimum 4, so the slave's synchronizer plus shift latency fits inside the high phase.
- CS_SETUP, 4: sysClk cycles from cs falling to the first bit's low phase.
- CS_HOLD, 4: sysClk cycles after the last spiClk falling edge before cs rises.
- BYTE_GAP, 8: sysClk cycles of idle spiClk low between bytes. The slave needs this to capture the byte and load its response.
- HW_ADDR, 3'b000: device hardware address embedded in the opcode.

Ports:
- sysClk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  1  request strobe; sampled only when ready_o=1.
- rw_i  in  1  1=read, 0=write.
- reg_addr_i  in  8  register address.
- wr_data_i  in  8  write data; ignored on reads.
- ready_o  out  1  idle and able to accept a request.
- busy_o  out  1  transaction in progress; equals !ready_o.
- done_o  out  1  one-cycle pulse at transaction end.
- rd_data_o  out  8  last read byte; held until the next read completes.
- spiClk_o  out  1  SPI clock, mode 0 (idle low).
- cs_o  out  1  chip select, active low.
- mosi_o  out  1  serial data to the slave, MSB first.
- miso_i  in  1  serial data from the slave; asynchronous to this block's sampling phase.

## Operation
- Reset values: cs_o=1, spiClk_o=0, mosi_o=0, ready_o=1, busy_o=0, done_o=0, rd_data_o=8'h00, state=MSIdle.
- Opcode byte = {4'b0100, HW_ADDR, rw_i}. Example: HW_ADDR=0 gives 8'h40 for a write and 8'h41 for a read.
- Accept: when req_i && ready_o, latch rw_i, reg_addr_i and wr_data_i into a 24-bit TX shift register, then go to MSSetup. req_i while busy is ignored and is not queued.
- States:
  - MSIdle: wait for an accepted request.
  - MSSetup: cs_o=0; wait CS_SETUP cycles.
  - MSLow: mosi_o = TX MSB; spiClk_o=0 for CLK_DIV cycles.
  - MSHigh: spiClk_o=1 for CLK_DIV cycles; MISO sampled on the last cycle.
  - MSGap: BYTE_GAP cycles with spiClk_o=0.
  - MSHold: CS_HOLD cycles.
  - MSDone: one cycle; cs_o=1, done_o=1; then MSIdle.
- Transitions: MSHigh → MSLow within a byte. After bits 7 and 15, MSHigh → MSGap → MSLow. After bit 23, MSHigh → MSHold.
- TX shifts left by one at the end of each MSHigh. RX shifts left by one, inserting a synchronized miso_i bit, on the last MSHigh cycle.
- miso_i passes through a 2-flop synchronizer. The sample point lies ≥2 cycles after the rising edge, so it is sampled from stable data.
- On reads, rd_data_o ← RX[7:0] (bits from the third byte) in the MSDone cycle. On writes, rd_data_o is unchanged.
- Counters:
  - 5-bit bit counter, 23→0, decrements at the end of each MSHigh.
  - Phase counter sized for max(CLK_DIV, CS_SETUP, CS_HOLD, BYTE_GAP), reloaded on every state entry.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronously). cs_o rises, aborting the frame; no done_o pulse.

## Timing
- Request accepted at edge N. cs_o falls at N+1, ready_o falls at N+1.
- First spiClk rising edge occurs at N+1+CS_SETUP+CLK_DIV.
- Total frame length from accept to done_o = 1 + CS_SETUP + 24·2·CLK_DIV + 2·BYTE_GAP + CS_HOLD cycles. With defaults this is 1+4+192+16+4 = 217.
- ready_o rises in the cycle after done_o. A new request can be accepted that same cycle, so cs_o is high for at least 1 cycle between frames plus MSIdle.
- mosi_o changes only at MSLow entry. It is stable for the whole high phase.

## Structure
- Shared package:
  - MasterState enum: MSIdle, MSSetup, MSLow, MSHigh, MSGap, MSHold, MSDone.
  - MCP_OPCODE_HI = 4'b0100.
  - Register address constants IOCON = 8'h0A, IODIR = 8'h00, GPIO = 8'h12.
- One sub-module: SPIPhaseTimer. It is a loadable down-counter with a terminal-count output, shared by all timed states.
- The miso synchronizer reuses CDCSynchron; only sync_o is used.

## Test plan
- Write IOCON (addr 8'h0A), data 8'h28, HW_ADDR=0 → mosi bytes 8'h40, 8'h0A, 8'h28; exactly 24 spiClk rising edges; one done_o pulse; rd_data_o unchanged.
- Read IOCON against the SPISlave model preloaded so that 0x41/0x0A yields 8'h28 → third-byte MISO is 8'h28; rd_data_o=8'h28 at done_o.
- Read address 8'h0F against SPISlave → rd_data_o=8'hF9. Then read with miso_i tied to 1 → rd_data_o=8'hFF.
- Pulse req_i during MSHigh of bit 5 → ignored; frame completes unchanged; exactly one done_o.
- Assert reset during byte 2 → cs_o=1 and spiClk_o=0 within the same cycle. After release, a new write completes correctly.
- Two back-to-back requests, with req_i held high across done_o → cs_o high ≥1 cycle between frames. Frame length is 217 cycles with defaults.
